// File: rtl/regfile_pkg.sv
// Shared register-file geometry for the write-back arbiter, register file and issue logic.
package regfile_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection: the first requester at or after the pointer wins (fixed priority from 0 when RR_EN = 0).
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter bit          RR_EN = 1'b1,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] pointer,
  output logic [NREQ-1:0]  grant
);

  logic        found;
  int unsigned base;
  int unsigned idx;

  // Circular scan from the pointer; the first valid requester takes the grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    base  = RR_EN ? 32'(pointer) : 32'd0;
    idx   = 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = base + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: picks one requester per cycle, registers the register-file write,
// and tracks outstanding destination registers in a busy scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter bit          RR_EN = 1'b1,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [REG_AW*NREQ-1:0]   req_reg,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr,
  output logic [REG_AW-1:0]        wreg,
  output logic [DATA_W-1:0]        wdata,
  input  logic                     sb_set,
  input  logic [REG_AW-1:0]        sb_reg,
  output logic [NREG-1:0]          busy
);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nxt_c;
  logic [NREQ-1:0]   grant_c;
  logic              xfer_c;
  logic [PTR_W-1:0]  sel_idx_c;
  logic [REG_AW-1:0] sel_reg_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [NREG-1:0]   busy_nxt_c;

  rr_arbiter #(
    .NREQ  (NREQ),
    .RR_EN (RR_EN)
  ) u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (grant_c)
  );

  // Grant is masked during reset so nothing is consumed while rst_n is low.
  assign req_ready = rst_n ? grant_c : '0;
  assign xfer_c    = |(req_valid & req_ready);

  always_comb begin
    sel_idx_c  = '0;
    sel_reg_c  = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_idx_c  = PTR_W'(i);
        sel_reg_c  = req_reg[REG_AW*i +: REG_AW];
        sel_data_c = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_nxt_c = ptr;
    if (!RR_EN) begin
      ptr_nxt_c = '0;
    end else if (xfer_c) begin
      if (sel_idx_c == PTR_W'(NREQ - 1)) ptr_nxt_c = '0;
      else                               ptr_nxt_c = sel_idx_c + PTR_W'(1);
    end
  end

  // Set beats clear when both hit the same register; register 0 never goes busy.
  always_comb begin
    busy_nxt_c = busy;
    if (wr) busy_nxt_c[wreg] = 1'b0;
    if (sb_set && (sb_reg != '0)) busy_nxt_c[sb_reg] = 1'b1;
    busy_nxt_c[0] = 1'b0;
  end

  // Writes to register 0 are consumed without touching the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      wr    <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
    end else begin
      ptr <= ptr_nxt_c;
      wr  <= xfer_c && (sel_reg_c != '0);
      if (xfer_c && (sel_reg_c != '0)) begin
        wreg  <= sel_reg_c;
        wdata <= sel_data_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt_c;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 3, number of write-back requesters; RR_EN, 1, 1 = round-robin, 0 = fixed priority (requester 0 highest).
REQ-002 Clocking SHALL be one clock domain; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NREQ  requester i has a write pending.
REQ-006 req_reg  input  5*NREQ  destination register; requester i at [5i+4:5i].
REQ-007 req_data  input  32*NREQ  write data; requester i at [32i+31:32i].
REQ-008 req_ready  output  NREQ  one-hot grant; the transfer for requester i occurs on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 wr  output  1  register-file write enable.
REQ-010 wreg  output  5  register-file write address.
REQ-011 wdata  output  32  register-file write data.
REQ-012 sb_set  input  1  issue stage marks a destination register as pending.
REQ-013 sb_reg  input  5  register to mark pending.
REQ-014 busy  output  32  scoreboard; busy[r] = 1 while a write to r is outstanding.

Function
REQ-015 req_ready SHALL be combinational from req_valid and the priority pointer, with at most one bit set per cycle and no bit set when req_valid = 0.
REQ-016 In round-robin mode, the grant SHALL go to the first valid requester at or after the pointer, wrapping from NREQ-1 to 0.
REQ-017 After a transfer to requester g, the pointer SHALL become (g+1) mod NREQ; with no transfer, the pointer SHALL hold.
REQ-018 When RR_EN = 0, the lowest-index valid requester SHALL always win and the pointer SHALL stay at 0.
REQ-019 Requesters SHALL hold req_valid, req_reg and req_data stable until their transfer completes; the arbiter SHALL NOT depend on withdrawal.
REQ-020 wr, wreg and wdata SHALL be registered: a transfer in cycle N SHALL produce wr = 1 with the granted reg/data in cycle N+1, for exactly one cycle per transfer.
REQ-021 A transfer with req_reg = 0 SHALL be consumed (ready asserted) but SHALL produce wr = 0 in cycle N+1.
REQ-022 When wr = 0, wreg and wdata SHALL hold their previous values.
REQ-023 Throughput SHALL be one transfer per cycle; back-to-back transfers SHALL produce wr = 1 on consecutive cycles.
REQ-024 busy[sb_reg] SHALL be set at the clock edge where sb_set = 1 and sb_reg != 0.
REQ-025 busy[wreg] SHALL be cleared at the clock edge ending a cycle in which wr = 1.
REQ-026 If a set and a clear target the same register on the same edge, the set SHALL win.
REQ-027 busy[0] SHALL always be 0.
REQ-028 A write to a register that is not busy SHALL still be performed, and busy SHALL stay 0 for it.

Reset
REQ-029 While rst_n = 0, outputs SHALL be: wr = 0, wreg = 0, wdata = 0, busy = 0; the pointer SHALL be 0.
REQ-030 req_ready SHALL be all zeros while rst_n = 0, regardless of req_valid.
REQ-031 Reset asserted mid-operation SHALL drop any registered pending write (no wr after release) and clear all busy bits.
REQ-032 The first transfer after reset release SHALL follow the pointer = 0 priority.

Structure
REQ-033 Package regfile_pkg SHALL hold REG_AW = 5, DATA_W = 32 and NREG = 32, shared with the register file and the issue logic.
REQ-034 Grant selection SHALL be a sub-module rr_arbiter (inputs: req, pointer, RR_EN; output: one-hot grant). Output registers and the scoreboard SHALL stay in the top level.

Verification
REQ-035 Only requester 1 valid, reg 7, data 0xDEADBEEF -> ready = 3'b010 same cycle; next cycle wr = 1, wreg = 7, wdata = 0xDEADBEEF; then wr = 0.
REQ-036 All three requesters held valid (regs 1, 2, 3), RR_EN = 1 -> grants 0, 1, 2 on consecutive cycles; wr = 1 for three consecutive cycles with wreg = 1, 2, 3.
REQ-037 Same stimulus with RR_EN = 0, where requester 0 drops after its transfer -> grants 0, 1, 2; with requester 0 held valid -> requester 0 is granted every cycle.
REQ-038 Requester with reg 0, data 0x55 -> ready asserted; next cycle wr = 0; busy unchanged.
REQ-039 sb_set with reg 9 -> busy[9] = 1; later transfer to reg 9 -> busy[9] clears on the edge after wr = 1. On a cycle with sb_set reg 9 and wr = 1 for wreg 9 -> busy[9] stays 1.
REQ-040 Transfer in cycle N, with rst_n pulsed low before cycle N+1 -> wr stays 0, busy = 0, and the next grant follows pointer 0.
